// File: rtl/vote_capture.sv
// Four-button vote capture: 2-flop synchronizers, per-channel debounce, and an
// IDLE/OPEN/LOCKED window that latches sticky votes for a downstream voter.
`timescale 1ns/1ps

module vote_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WINDOW_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic       start,
  input  logic       clear,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       window_open,
  output logic       vote_valid,
  output logic [7:0] window_left
);

  typedef enum logic [1:0] {IDLE, OPEN, LOCKED} state_e;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] WIN_LOAD = 8'(WINDOW_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] deb_q, deb_d, deb_prev_q;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];
  logic [3:0] rise;
  logic [3:0] votes_q, votes_d;
  logic [7:0] left_q, left_d;

  // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = ~deb_q[i];
        else                      cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Rise is seen the cycle after the debounced toggle, giving 2 + N + 1 latency.
  assign rise = deb_q & ~deb_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      votes_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      votes_q <= votes_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!clear && start) state_d = OPEN;
      OPEN:    if (clear) state_d = IDLE;
               else if (left_q == 8'd1) state_d = LOCKED;
      LOCKED:  if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    votes_d = votes_q;
    left_d  = left_q;
    unique case (state_q)
      IDLE: begin
        votes_d = '0;
        left_d  = (state_d == OPEN) ? WIN_LOAD : 8'd0;
      end
      OPEN: begin
        if (clear) begin
          votes_d = '0;
          left_d  = '0;
        end else begin
          votes_d = votes_q | rise;
          left_d  = left_q - 8'd1;
        end
      end
      LOCKED: begin
        left_d = '0;
        if (clear) votes_d = '0;
      end
      default: begin
        votes_d = '0;
        left_d  = '0;
      end
    endcase
  end

  always_comb begin
    window_open  = (state_q == OPEN);
    vote_valid   = (state_q == LOCKED);
    {a, b, c, d} = votes_q;
    window_left  = left_q;
  end

endmodule
